// File: rtl/hdmi_packet_scheduler_if.sv
// rtl/hdmi_packet_scheduler_if.sv - port bundle between the packet scheduler and its sources/TMDS mux
interface hdmi_packet_scheduler_if #(
  parameter int NUM_SOURCES = 4,
  parameter int BIT_WIDTH   = 11
);
  logic [BIT_WIDTH:0]     cx;
  logic [BIT_WIDTH:0]     screen_start_x;
  logic [NUM_SOURCES-1:0] req;
  logic [NUM_SOURCES-1:0] ack;
  logic [2:0]             grant_index;
  logic                   island_preamble;
  logic                   island_guard;
  logic                   island_period;
  logic                   island_first;
  logic [4:0]             packet_counter;
  logic                   busy;

  modport master (
    input  cx, screen_start_x, req,
    output ack, grant_index, island_preamble, island_guard, island_period,
           island_first, packet_counter, busy
  );

  modport slave (
    output cx, screen_start_x, req,
    input  ack, grant_index, island_preamble, island_guard, island_period,
           island_first, packet_counter, busy
  );
endinterface

// File: rtl/hdmi_packet_scheduler.sv
// rtl/hdmi_packet_scheduler.sv - data island sequencer and packet-slot arbiter (HDMI_SCHED_ROUND_ROBIN_EN selects round-robin)
module hdmi_packet_scheduler #(
  parameter int NUM_SOURCES = 4,
  parameter int BIT_WIDTH   = 11,
  parameter int MAX_PACKETS = 18,
  parameter int MIN_CONTROL = 12,
  parameter int DVI_OUTPUT  = 0
) (
  input logic clk_pixel,
  input logic reset_n,
  hdmi_packet_scheduler_if.master bus
);
  localparam int XW = BIT_WIDTH + 2;

  typedef enum logic [2:0] {
    S_IDLE, S_PREAMBLE, S_LEAD_GUARD, S_PACKET, S_TRAIL_GUARD, S_COOLDOWN
  } state_t;

  state_t                 state, state_n;
  logic [7:0]             phase, phase_n;
  logic [4:0]             pkt_cnt, pkt_cnt_n;
  logic [7:0]             sent, sent_n;
  logic [2:0]             grant, grant_n;
  logic                   grant_load;
  logic [2:0]             search_base;
  logic [XW-1:0]          cx_w, ssx_w;
  logic                   start_ok, cont_ok;
  logic [NUM_SOURCES-1:0] grant_oh, eligible;

  // First set bit of m at or after base, wrapping around.
  function automatic logic [2:0] pick(input logic [NUM_SOURCES-1:0] m, input logic [2:0] base);
    logic [NUM_SOURCES-1:0] rot;
    logic [3:0]             off, idx;
    rot = NUM_SOURCES'({m, m} >> base);
    off = 4'd0;
    for (int i = NUM_SOURCES - 1; i >= 0; i--)
      if (rot[i]) off = 4'(i);
    idx = {1'b0, base} + off;
    if (idx >= 4'(NUM_SOURCES)) idx = idx - 4'(NUM_SOURCES);
    return idx[2:0];
  endfunction

`ifdef HDMI_SCHED_ROUND_ROBIN_EN
  logic [2:0] rr_ptr;

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n)        rr_ptr <= 3'd0;
    else if (grant_load) rr_ptr <= grant_n;
  end

  assign search_base = (rr_ptr == 3'(NUM_SOURCES - 1)) ? 3'd0 : rr_ptr + 3'd1;
`else
  assign search_base = 3'd0;
`endif

  // Window checks compare against screen_start_x directly so W never underflows.
  assign cx_w     = XW'(bus.cx);
  assign ssx_w    = XW'(bus.screen_start_x);
  assign grant_oh = NUM_SOURCES'(1) << grant;
  assign eligible = bus.req & ~grant_oh;

  assign start_ok = (DVI_OUTPUT == 0) && (|bus.req)
                 && (cx_w >= XW'(MIN_CONTROL - 1))
                 && (cx_w + XW'(MIN_CONTROL + 55) <= ssx_w)
                 && (ssx_w >= XW'(2 * MIN_CONTROL + 55));

  assign cont_ok  = (|eligible) && (sent < 8'(MAX_PACKETS))
                 && (cx_w + XW'(MIN_CONTROL + 45) <= ssx_w);

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      phase   <= 8'd0;
      pkt_cnt <= 5'd0;
      sent    <= 8'd0;
      grant   <= 3'd0;
    end else begin
      state   <= state_n;
      phase   <= phase_n;
      pkt_cnt <= pkt_cnt_n;
      sent    <= sent_n;
      grant   <= grant_n;
    end
  end

  always_comb begin
    state_n    = state;
    phase_n    = phase;
    pkt_cnt_n  = pkt_cnt;
    sent_n     = sent;
    grant_n    = grant;
    grant_load = 1'b0;

    case (state)
      S_IDLE: begin
        if (start_ok) begin
          state_n    = S_PREAMBLE;
          phase_n    = 8'd0;
          sent_n     = 8'd1;
          grant_n    = pick(bus.req, search_base);
          grant_load = 1'b1;
        end
      end
      S_PREAMBLE: begin
        if (phase == 8'd7) begin
          state_n = S_LEAD_GUARD;
          phase_n = 8'd0;
        end else begin
          phase_n = phase + 8'd1;
        end
      end
      S_LEAD_GUARD: begin
        if (phase == 8'd1) begin
          state_n   = S_PACKET;
          phase_n   = 8'd0;
          pkt_cnt_n = 5'd0;
        end else begin
          phase_n = phase + 8'd1;
        end
      end
      S_PACKET: begin
        // The 5-bit wrap leaves the counter at 0 whether we continue or leave.
        pkt_cnt_n = pkt_cnt + 5'd1;
        if (pkt_cnt == 5'd31) begin
          if (cont_ok) begin
            grant_n    = pick(eligible, search_base);
            grant_load = 1'b1;
            sent_n     = sent + 8'd1;
          end else begin
            state_n = S_TRAIL_GUARD;
            phase_n = 8'd0;
          end
        end
      end
      S_TRAIL_GUARD: begin
        if (phase == 8'd1) begin
          state_n = S_COOLDOWN;
          phase_n = 8'd0;
        end else begin
          phase_n = phase + 8'd1;
        end
      end
      S_COOLDOWN: begin
        if (phase == 8'(MIN_CONTROL - 1)) begin
          state_n = S_IDLE;
          phase_n = 8'd0;
        end else begin
          phase_n = phase + 8'd1;
        end
      end
      default: state_n = S_IDLE;
    endcase

    bus.busy            = (state != S_IDLE);
    bus.island_preamble = (state == S_PREAMBLE);
    bus.island_guard    = (state == S_LEAD_GUARD) || (state == S_TRAIL_GUARD);
    bus.island_period   = (state == S_PACKET);
    bus.island_first    = (state == S_PACKET) && (pkt_cnt == 5'd0) && (sent == 8'd1);
    bus.packet_counter  = pkt_cnt;
    bus.grant_index     = grant;
    bus.ack             = ((state == S_PACKET) && (pkt_cnt == 5'd31)) ? grant_oh : '0;
  end
endmodule
